// File: rtl/mcycle_pkg.sv
// ---------------------------------------------------------------------------
// mcycle_pkg
// Shared definitions for the multi-cycle multiply/divide controller:
//   - DEFAULT_WIDTH  : default operand width / iteration count
//   - mcycle_state_e : controller FSM states
//   - mcycle_op_e    : operation encoding (OP_MUL = 0, OP_DIV = 1)
// ---------------------------------------------------------------------------
package mcycle_pkg;

    localparam int DEFAULT_WIDTH = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_WB   = 2'd3
    } mcycle_state_e;

    typedef enum logic {
        OP_MUL = 1'b0,
        OP_DIV = 1'b1
    } mcycle_op_e;

endpackage

// File: rtl/mcycle_iter_cnt.sv
// ---------------------------------------------------------------------------
// mcycle_iter_cnt
// Iteration counter for the multi-cycle unit. Counts 0 .. WIDTH-1 while
// enabled and wraps back to 0 after the last iteration.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   clear      : synchronous clear (wins over enable)
//   enable     : advance one iteration
//   count      : current iteration index
//   tc         : terminal count, high when count == WIDTH-1
// ---------------------------------------------------------------------------
import mcycle_pkg::*;

module mcycle_iter_cnt #(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             enable,
    output logic [CNT_W-1:0] count,
    output logic             tc
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    assign count = count_q;
    assign tc    = (count_q == LAST);

    // Explicit wrap at the terminal count so non-power-of-two widths also
    // return to zero for the next operation.
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable) begin
            count_d = tc ? '0 : count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/mcycle_ctrl.sv
// ---------------------------------------------------------------------------
// mcycle_ctrl
// Control FSM for an iterative multiply/divide unit. Accepts an MCycle op
// from Execute, loads the datapath, steps it WIDTH times (skipped on a
// divide-by-zero), then holds a write-back request until the register file
// grants a slot.
// Ports:
//   CLK, RESETn            : clock, asynchronous active-low reset
//   StartE, OpE, DivZeroE  : op start, op type, divisor-is-zero flag
//   WA3E                   : destination register of the started op
//   FlushE, Abort          : Execute flush (masks start), kill in-flight op
//   RA1D, RA2D, WA3D       : Decode registers checked for RAW hazards
//   WbGrant                : register-file write slot available
//   DpLoad, DpStep, Count  : datapath load / iterate strobes, iteration index
//   WbReq, M_Busy, M_Done  : write-back request, op in flight, done pulse
//   WA3R, OpR, DivZeroR    : latched attributes of the current/last op
//   RAWStall               : Decode must stall on the in-flight destination
//   OverrunErr             : sticky flag, start seen while busy
// ---------------------------------------------------------------------------
import mcycle_pkg::*;

module mcycle_ctrl #(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             CLK,
    input  logic             RESETn,
    input  logic             StartE,
    input  logic             OpE,
    input  logic             DivZeroE,
    input  logic [3:0]       WA3E,
    input  logic             FlushE,
    input  logic             Abort,
    input  logic [3:0]       RA1D,
    input  logic [3:0]       RA2D,
    input  logic [3:0]       WA3D,
    input  logic             WbGrant,
    output logic             DpLoad,
    output logic             DpStep,
    output logic [CNT_W-1:0] Count,
    output logic             WbReq,
    output logic             M_Busy,
    output logic             M_Done,
    output logic [3:0]       WA3R,
    output logic             OpR,
    output logic             DivZeroR,
    output logic             RAWStall,
    output logic             OverrunErr
);

    mcycle_state_e state_q, state_d;
    logic [3:0]    wa3_q, wa3_d;
    mcycle_op_e    op_q, op_d;
    logic          dz_q, dz_d;
    logic          overrun_q, overrun_d;

    logic start_ok;
    logic accept;
    logic cnt_clear;
    logic cnt_en;
    logic cnt_tc;

    // Abort outranks any start, so a start in the same cycle neither
    // launches an op nor counts as an overrun.
    assign start_ok  = StartE & ~FlushE & ~Abort;
    assign cnt_clear = Abort | (state_q != ST_RUN);

    mcycle_iter_cnt #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_iter_cnt (
        .clk    (CLK),
        .rst_n  (RESETn),
        .clear  (cnt_clear),
        .enable (cnt_en),
        .count  (Count),
        .tc     (cnt_tc)
    );

    // Next-state and strobe logic. A start is taken in IDLE, or in WB on
    // the same cycle the write slot is granted (back-to-back ops); any other
    // start while busy is dropped and flagged as an overrun.
    always_comb begin
        state_d   = state_q;
        wa3_d     = wa3_q;
        op_d      = op_q;
        dz_d      = dz_q;
        overrun_d = overrun_q;
        accept    = 1'b0;
        DpLoad    = 1'b0;
        DpStep    = 1'b0;
        WbReq     = 1'b0;
        M_Done    = 1'b0;
        cnt_en    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start_ok) begin
                    accept = 1'b1;
                end
            end
            ST_LOAD: begin
                DpLoad  = 1'b1;
                state_d = dz_q ? ST_WB : ST_RUN;
                if (start_ok) begin
                    overrun_d = 1'b1;
                end
            end
            ST_RUN: begin
                DpStep = 1'b1;
                cnt_en = 1'b1;
                if (cnt_tc) begin
                    state_d = ST_WB;
                end
                if (start_ok) begin
                    overrun_d = 1'b1;
                end
            end
            ST_WB: begin
                WbReq = 1'b1;
                if (WbGrant) begin
                    M_Done  = 1'b1;
                    state_d = ST_IDLE;
                    if (start_ok) begin
                        accept = 1'b1;
                    end
                end else if (start_ok) begin
                    overrun_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (accept) begin
            state_d = ST_LOAD;
            wa3_d   = WA3E;
            op_d    = mcycle_op_e'(OpE);
            dz_d    = DivZeroE;
        end

        if (Abort) begin
            state_d = ST_IDLE;
            WbReq   = 1'b0;
            M_Done  = 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            state_q   <= ST_IDLE;
            wa3_q     <= '0;
            op_q      <= OP_MUL;
            dz_q      <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wa3_q     <= wa3_d;
            op_q      <= op_d;
            dz_q      <= dz_d;
            overrun_q <= overrun_d;
        end
    end

    assign M_Busy     = (state_q != ST_IDLE);
    assign WA3R       = wa3_q;
    assign OpR        = (op_q == OP_DIV);
    assign DivZeroR   = dz_q;
    assign OverrunErr = overrun_q;

    // Once the done pulse fires the result is being written this cycle, so
    // Decode can read it through the register file without stalling.
    assign RAWStall = M_Busy & ~M_Done &
                      ((RA1D == wa3_q) | (RA2D == wa3_q) | (WA3D == wa3_q));

endmodule
